// File: rtl/latch_response_monitor.sv
// latch_response_monitor: clocked observer for a NOR/OR-loop latch experiment.
// Measures trigger pulse width, first-rise delay, final latch state and output toggles.
module latch_response_monitor #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 150,
  parameter int TOG_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             pulse_in,
  input  logic             latch_out,
  input  logic             result_ack,
  output logic             busy,
  output logic             arm_err,
  output logic             result_valid,
  output logic [CNT_W-1:0] pulse_width,
  output logic [CNT_W-1:0] resp_delay,
  output logic             latched,
  output logic [TOG_W-1:0] toggles,
  output logic             overflow
);

  localparam int                SCNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [TOG_W-1:0]  TOG_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PULSE,
    S_SETTLE,
    S_REPORT
  } state_t;

  state_t            state, state_next;
  logic              pulse_meta, pulse_s;
  logic              latch_meta, latch_s, latch_prev;
  logic [SCNT_W-1:0] scnt;
  logic [CNT_W-1:0]  rel, rel_now;
  logic              rise_seen;
  logic              accept_arm, pulse_start, tracking, settle_last;
  logic              latch_rise, latch_edge;

  // Both inputs share the same two-stage depth so their relative timing survives.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_meta <= 1'b0;
      pulse_s    <= 1'b0;
      latch_meta <= 1'b0;
      latch_s    <= 1'b0;
      latch_prev <= 1'b0;
    end else begin
      pulse_meta <= pulse_in;
      pulse_s    <= pulse_meta;
      latch_meta <= latch_out;
      latch_s    <= latch_meta;
      latch_prev <= latch_s;
    end
  end

  assign accept_arm  = (state == S_IDLE) && arm && !latch_s;
  assign pulse_start = (state == S_WAIT) && pulse_s;
  assign tracking    = pulse_start || (state == S_PULSE) || (state == S_SETTLE);
  assign settle_last = (state == S_SETTLE) && (scnt == SCNT_LAST);
  assign latch_rise  = latch_s && !latch_prev;
  assign latch_edge  = latch_s ^ latch_prev;
  // The pulse-rise cycle is offset 0 even though rel still holds a stale value.
  assign rel_now     = pulse_start ? '0 : rel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    result_valid = 1'b0;
    unique case (state)
      S_IDLE:   if (accept_arm) state_next = S_WAIT;
      S_WAIT:   if (pulse_s) state_next = S_PULSE;
      S_PULSE:  if (!pulse_s) state_next = S_SETTLE;
      S_SETTLE: if (settle_last) state_next = S_REPORT;
      S_REPORT: if (result_ack) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (state != S_IDLE)   busy         = 1'b1;
    if (state == S_REPORT) result_valid = 1'b1;
  end

  // NOTE: all measurement registers reset, since outputs must read 0 while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_err     <= 1'b0;
      pulse_width <= '0;
      resp_delay  <= '0;
      latched     <= 1'b0;
      toggles     <= '0;
      overflow    <= 1'b0;
      rel         <= '0;
      rise_seen   <= 1'b0;
      scnt        <= '0;
    end else begin
      arm_err <= (state == S_IDLE) && arm && latch_s;

      if (accept_arm) begin
        pulse_width <= '0;
        resp_delay  <= '0;
        toggles     <= '0;
        overflow    <= 1'b0;
        rel         <= '0;
        rise_seen   <= 1'b0;
      end

      if (pulse_start) begin
        pulse_width <= CNT_W'(1);
      end else if ((state == S_PULSE) && pulse_s) begin
        if (pulse_width != CNT_MAX) pulse_width <= pulse_width + 1'b1;
        else                        overflow    <= 1'b1;
      end

      if (tracking) begin
        rel <= (rel_now != CNT_MAX) ? rel_now + 1'b1 : rel_now;
        if (latch_rise && !rise_seen) begin
          resp_delay <= rel_now;
          rise_seen  <= 1'b1;
        end
        if (latch_edge && (toggles != TOG_MAX)) toggles <= toggles + 1'b1;
      end

      if ((state == S_PULSE) && !pulse_s) scnt <= '0;
      else if (state == S_SETTLE)         scnt <= scnt + 1'b1;

      if (settle_last) begin
        latched <= latch_s;
        if (!rise_seen && !latch_rise) resp_delay <= '1;
      end
    end
  end

endmodule

// File: tb/tb_latch_response_monitor.sv
// Directed bench for latch_response_monitor: expected results are queued at launch
// and compared when result_valid appears; a CNT_W=4 copy covers width saturation.
module tb_latch_response_monitor;

  localparam int SETTLE = 150;

  typedef struct {
    logic [15:0] width;
    logic [15:0] delay;
    logic        latched;
    logic [7:0]  toggles;
    logic        overflow;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, arm, arm_b, pulse_in, latch_out, result_ack, ack_b;
  logic        busy, arm_err, result_valid, latched, overflow;
  logic [15:0] pulse_width, resp_delay;
  logic [7:0]  toggles;
  logic        busy_b, arm_err_b, valid_b, latched_b, overflow_b;
  logic [3:0]  width_b, delay_b;
  logic [7:0]  toggles_b;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t exp_bq[$];
  exp_t held;

  latch_response_monitor #(.CNT_W(16), .SETTLE_CYCLES(SETTLE), .TOG_W(8)) dut (
    .clk(clk), .rst(rst), .arm(arm), .pulse_in(pulse_in), .latch_out(latch_out),
    .result_ack(result_ack), .busy(busy), .arm_err(arm_err), .result_valid(result_valid),
    .pulse_width(pulse_width), .resp_delay(resp_delay), .latched(latched),
    .toggles(toggles), .overflow(overflow)
  );

  latch_response_monitor #(.CNT_W(4), .SETTLE_CYCLES(SETTLE), .TOG_W(8)) dut_b (
    .clk(clk), .rst(rst), .arm(arm_b), .pulse_in(pulse_in), .latch_out(latch_out),
    .result_ack(ack_b), .busy(busy_b), .arm_err(arm_err_b), .result_valid(valid_b),
    .pulse_width(width_b), .resp_delay(delay_b), .latched(latched_b),
    .toggles(toggles_b), .overflow(overflow_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Latch level at cycle k after the pulse rise; holds the last pattern bit afterwards.
  function automatic logic pat_at(input logic [63:0] pat, input int plen, input int k);
    if (plen == 0) return 1'b0;
    if (k < plen)  return pat[k];
    return pat[plen-1];
  endfunction

  function automatic exp_t model(input int pw, input logic [63:0] pat, input int plen,
                                 input int cnt_w);
    exp_t e;
    int   maxv;
    logic prev, cur;
    bit   seen;
    maxv       = (1 << cnt_w) - 1;
    e.width    = 16'((pw > maxv) ? maxv : pw);
    e.overflow = (pw > maxv);
    e.delay    = 16'(maxv);
    e.toggles  = 8'd0;
    seen = 1'b0;
    prev = 1'b0;
    cur  = 1'b0;
    for (int k = 0; k <= pw + SETTLE; k++) begin
      cur = pat_at(pat, plen, k);
      if (cur && !prev && !seen) begin
        seen    = 1'b1;
        e.delay = 16'((k > maxv) ? maxv : k);
      end
      if ((cur != prev) && (e.toggles != 8'hFF)) e.toggles = e.toggles + 8'd1;
      prev = cur;
    end
    e.latched = cur;
    return e;
  endfunction

  task automatic launch(input int pw, input logic [63:0] pat, input int plen, input bit use_b);
    int len;
    latch_out = 1'b0;
    pulse_in  = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(model(pw, pat, plen, 16));
    if (use_b) exp_bq.push_back(model(pw, pat, plen, 4));
    arm   = 1'b1;
    arm_b = use_b;
    @(negedge clk);
    arm   = 1'b0;
    arm_b = 1'b0;
    check("busy_after_arm", busy, 1);
    check("arm_err_on_accept", arm_err, 0);
    @(negedge clk);
    len = ((pw > plen) ? pw : plen) + 2;
    for (int k = 0; k < len; k++) begin
      pulse_in  = (k < pw);
      latch_out = pat_at(pat, plen, k);
      @(negedge clk);
    end
    pulse_in = 1'b0;
  endtask

  task automatic await_result();
    int n;
    n = 0;
    while ((result_valid !== 1'b1) && (n < SETTLE + 100)) begin
      @(negedge clk);
      n++;
    end
    check("result_valid", result_valid, 1);
  endtask

  task automatic compare_main(input exp_t e);
    check("pulse_width", pulse_width, e.width);
    check("resp_delay", resp_delay, e.delay);
    check("latched", latched, e.latched);
    check("toggles", toggles, e.toggles);
    check("overflow", overflow, e.overflow);
  endtask

  task automatic compare_b(input exp_t e);
    check("b_result_valid", valid_b, 1);
    check("b_busy", busy_b, 1);
    check("b_pulse_width", width_b, e.width);
    check("b_resp_delay", delay_b, e.delay);
    check("b_latched", latched_b, e.latched);
    check("b_toggles", toggles_b, e.toggles);
    check("b_overflow", overflow_b, e.overflow);
  endtask

  task automatic ack_result(input bit use_b);
    result_ack = 1'b1;
    ack_b      = use_b;
    @(negedge clk);
    check("valid_after_ack", result_valid, 0);
    check("busy_after_ack", busy, 0);
    if (use_b) check("b_valid_after_ack", valid_b, 0);
    result_ack = 1'b0;
    ack_b      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_arm_err"}, arm_err, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_width"}, pulse_width, 0);
    check({tag, "_delay"}, resp_delay, 0);
    check({tag, "_latched"}, latched, 0);
    check({tag, "_toggles"}, toggles, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    bit seen_valid;
    rst        = 1'b1;
    arm        = 1'b0;
    arm_b      = 1'b0;
    pulse_in   = 1'b0;
    latch_out  = 1'b0;
    result_ack = 1'b0;
    ack_b      = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // T1: 12-cycle pulse, latch rises 3 cycles after pulse rise and stays high.
    launch(12, 64'h8, 4, 1'b0);
    await_result();
    compare_main(exp_q.pop_front());
    ack_result(1'b0);

    // T2: 4-cycle pulse, latch never rises.
    launch(4, 64'h0, 0, 1'b0);
    await_result();
    compare_main(exp_q.pop_front());
    ack_result(1'b0);

    // T3: latch rings 1,0,1,0 then settles low.
    launch(8, 64'h38E0, 15, 1'b0);
    await_result();
    compare_main(exp_q.pop_front());
    ack_result(1'b0);

    // T4: 20-cycle pulse seen by both the 16-bit and the 4-bit monitor.
    launch(20, 64'h4, 3, 1'b1);
    await_result();
    compare_main(exp_q.pop_front());
    compare_b(exp_bq.pop_front());
    ack_result(1'b1);

    // T5: reset during SETTLE discards the measurement.
    launch(5, 64'h2, 2, 1'b0);
    repeat (20) @(negedge clk);
    check("busy_in_settle", busy, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (SETTLE + 50) begin
      @(negedge clk);
      if (result_valid === 1'b1) seen_valid = 1'b1;
    end
    check("no_valid_after_reset", seen_valid, 0);
    check("idle_after_reset", busy, 0);
    // latch_out is still high here, so the arm must be refused.
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("arm_err_pulse", arm_err, 1);
    check("busy_on_reject", busy, 0);
    check("b_arm_err_unarmed", arm_err_b, 0);
    @(negedge clk);
    check("arm_err_one_cycle", arm_err, 0);
    check("busy_after_reject", busy, 0);

    // T6: result held without ack; arm in REPORT ignored; new arm accepted after ack.
    launch(6, 64'h2, 2, 1'b0);
    await_result();
    held = exp_q.pop_front();
    compare_main(held);
    for (int i = 0; i < 10; i++) begin
      arm = (i == 3);
      @(negedge clk);
      check("hold_valid", result_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_arm_err", arm_err, 0);
      check("hold_width", pulse_width, held.width);
      check("hold_delay", resp_delay, held.delay);
      check("hold_toggles", toggles, held.toggles);
      check("hold_latched", latched, held.latched);
    end
    arm = 1'b0;
    ack_result(1'b0);
    launch(3, 64'h0, 0, 1'b0);
    await_result();
    compare_main(exp_q.pop_front());
    ack_result(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
